radix_counter: RTL and testbench
================================

RADIX_COUNTER -- requirements
Module: radix_counter

Interface
REQ-001 Parameter PRESCALE, default 50000000, SHALL set clk cycles per count tick (1 Hz at 50 MHz); legal range 2..2^26.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  count enable; counters SHALL advance only on ticks while en=1.
REQ-005 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 load  input  1  synchronous load strobe.
REQ-007 load_val  input  4  value applied on load.
REQ-008 hex  output  4  radix-16 digit, 0..15.
REQ-009 binary  output  4  radix-2 digit in bit 0; bits 3:1 SHALL always be 0.
REQ-010 baseten  output  4  radix-10 digit, 0..9.
REQ-011 tick  output  1  one-cycle pulse every PRESCALE cycles.
REQ-012 wrap  output  3  one-cycle wrap flags {dec, bin, hex}.

Function
REQ-013 Prescaler SHALL count 0..PRESCALE-1 and assert tick for exactly one cycle when it reaches PRESCALE-1, then return to 0.
REQ-014 Prescaler SHALL run regardless of en; en gates counting only.
REQ-015 On a cycle with tick=1, en=1, load=0, all three counters SHALL step together by +1 (up=1) or -1 (up=0); outputs update on the following clk edge.
REQ-016 Up wrap: hex 15->0, binary 1->0, baseten 9->0; down wrap: hex 0->15, binary 0->1, baseten 0->9.
REQ-017 On any wrap, the matching wrap bit SHALL be 1 for exactly the cycle after the stepping edge, else 0.
REQ-018 load=1 SHALL take priority over counting, irrespective of tick/en: hex<=load_val, binary<=load_val[0], baseten<=load_val if load_val<=9 else 9.
REQ-019 load SHALL NOT reset the prescaler and SHALL NOT assert any wrap bit.
REQ-020 Direction change SHALL take effect on the next tick; no state is retained about previous direction.
REQ-021 baseten SHALL never hold 10..15; binary bits 3:1 SHALL never be nonzero.
REQ-022 Outputs SHALL be registered; no combinational path from inputs to hex/binary/baseten/wrap.

Reset
REQ-023 rst=1 at a clk edge SHALL set hex=0, binary=0, baseten=0, wrap=000, tick=0, prescaler=0.
REQ-024 rst SHALL override load, en and tick on the same edge, including mid-count.
REQ-025 First tick after rst deassertion SHALL occur PRESCALE cycles after the first edge with rst=0.

Structure
REQ-026 Shared package SHALL hold radix limits (HEX_MAX=15, BIN_MAX=1, DEC_MAX=9) and digit width 4.
REQ-027 Prescaler SHALL be a sub-module tick_gen (params PRESCALE; ports clk, rst, tick).
REQ-028 Three counters SHALL share one generic step rule parameterized by radix limit; target 150-250 RTL lines.

Verification (PRESCALE=4)
REQ-029 rst 2 cycles, en=1, up=1, 40 cycles -> tick every 4th cycle; after 10 ticks hex=10, binary=0, baseten=0, wrap[2] pulsed once.
REQ-030 en=1, up=0 from reset -> first tick gives hex=15, binary=1, baseten=9, wrap=111 for one cycle.
REQ-031 load=1, load_val=12 -> hex=12, binary=0, baseten=9, wrap=000; load coinciding with tick -> load values, no step.
REQ-032 en=0 for 20 cycles -> outputs frozen, tick still pulses every 4 cycles.
REQ-033 rst asserted on a tick cycle with load=1 -> all outputs 0 next edge; next tick exactly 4 cycles after release.
REQ-034 Random en/up/load over 10000 cycles vs reference model -> exact match; baseten<=9, binary[3:1]=0 throughout.

Source files
------------

// File: rtl/radix_counter_pkg.sv
// Shared radix limits, digit width and the single step rule used by every digit counter.
package radix_counter_pkg;

   localparam int unsigned DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] HEX_MAX = 4'd15;
   localparam logic [DIGIT_W-1:0] BIN_MAX = 4'd1;
   localparam logic [DIGIT_W-1:0] DEC_MAX = 4'd9;

   // Wrap flag bit positions within the wrap output.
   localparam int unsigned WRAP_HEX = 0;
   localparam int unsigned WRAP_BIN = 1;
   localparam int unsigned WRAP_DEC = 2;

   typedef struct packed {
      logic               wrap;
      logic [DIGIT_W-1:0] digit;
   } step_t;

   // One step of a digit with range 0..max; ">=" keeps an out-of-range digit recoverable.
   function automatic step_t radix_step(input logic [DIGIT_W-1:0] cur,
                                        input logic [DIGIT_W-1:0] max,
                                        input logic               up);
      step_t r;
      r.wrap  = 1'b0;
      r.digit = cur;
      if (up) begin
         if (cur >= max) begin
            r.wrap  = 1'b1;
            r.digit = '0;
         end else begin
            r.digit = cur + 4'd1;
         end
      end else begin
         if (cur == '0) begin
            r.wrap  = 1'b1;
            r.digit = max;
         end else begin
            r.digit = cur - 4'd1;
         end
      end
      return r;
   endfunction

   function automatic logic [DIGIT_W-1:0] clamp_dec(input logic [DIGIT_W-1:0] v);
      return (v > DEC_MAX) ? DEC_MAX : v;
   endfunction

endpackage

// File: rtl/radix_counter_tick_gen.sv
// Free-running prescaler: counts 0..PRESCALE-1 and pulses tick while at PRESCALE-1.
module tick_gen #(
   parameter int unsigned PRESCALE = 50000000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

   logic [CW-1:0] cnt;

   // tick is registered one count early so it is high exactly while cnt == PRESCALE-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == CW'(PRESCALE - 1)) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= cnt + 1'b1;
         tick <= (cnt == CW'(PRESCALE - 2));
      end
   end

endmodule

// File: rtl/radix_counter.sv
// Hex, binary and decimal digit counters stepping together on prescaler ticks.
module radix_counter
   import radix_counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 50000000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         up,
   input  logic         load,
   input  logic [3:0]   load_val,
   output logic [3:0]   hex,
   output logic [3:0]   binary,
   output logic [3:0]   baseten,
   output logic         tick,
   output logic [2:0]   wrap
);

   step_t hex_s;
   step_t bin_s;
   step_t dec_s;

   tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   always_comb begin
      hex_s = radix_step(hex,     HEX_MAX, up);
      bin_s = radix_step(binary,  BIN_MAX, up);
      dec_s = radix_step(baseten, DEC_MAX, up);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hex     <= '0;
         binary  <= '0;
         baseten <= '0;
         wrap    <= '0;
      end else begin
         wrap <= '0;
         if (load) begin
            hex     <= load_val;
            binary  <= {3'b000, load_val[0]};
            baseten <= clamp_dec(load_val);
         end else if (tick && en) begin
            hex            <= hex_s.digit;
            binary         <= bin_s.digit;
            baseten        <= dec_s.digit;
            wrap[WRAP_HEX] <= hex_s.wrap;
            wrap[WRAP_BIN] <= bin_s.wrap;
            wrap[WRAP_DEC] <= dec_s.wrap;
         end
      end
   end

endmodule

// File: tb/tb_radix_counter.sv
// Self-checking bench for radix_counter (PRESCALE=4) against a modular-arithmetic model.
module tb_radix_counter;

   localparam int P = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [3:0] hex;
   logic [3:0] binary;
   logic [3:0] baseten;
   logic       tick;
   logic [2:0] wrap;

   int checks = 0;
   int failures = 0;

   int m_hex = 0, m_bin = 0, m_dec = 0, m_wrap = 0, m_n = 0;
   int m_tick = 0;
   int cnt_tick, cnt_w2;

   radix_counter #(.PRESCALE(P)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .hex      (hex),
      .binary   (binary),
      .baseten  (baseten),
      .tick     (tick),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         failures++;
         $error("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Model: digits are integers modulo their radix; tick is high in the cycle where the
   // number of non-reset edges since reset is congruent to P-1 modulo P.
   task automatic cyc();
      int lv;
      @(posedge clk);
      lv = int'(load_val);
      if (rst) begin
         m_hex = 0; m_bin = 0; m_dec = 0; m_wrap = 0; m_n = 0; m_tick = 0;
      end else begin
         m_wrap = 0;
         if (load) begin
            m_hex = lv;
            m_bin = lv % 2;
            m_dec = (lv > 9) ? 9 : lv;
         end else if (m_tick == 1 && en) begin
            if (up) begin
               if (m_hex == 15) m_wrap += 1;
               if (m_bin == 1)  m_wrap += 2;
               if (m_dec == 9)  m_wrap += 4;
               m_hex = (m_hex + 1) % 16;
               m_bin = (m_bin + 1) % 2;
               m_dec = (m_dec + 1) % 10;
            end else begin
               if (m_hex == 0) m_wrap += 1;
               if (m_bin == 0) m_wrap += 2;
               if (m_dec == 0) m_wrap += 4;
               m_hex = (m_hex + 15) % 16;
               m_bin = (m_bin + 1) % 2;
               m_dec = (m_dec + 9) % 10;
            end
         end
         m_n++;
         m_tick = (m_n % P == P - 1) ? 1 : 0;
      end
      #1;
      chk("hex", 32'(hex), 32'(m_hex));
      chk("binary", 32'(binary), 32'(m_bin));
      chk("baseten", 32'(baseten), 32'(m_dec));
      chk("wrap", 32'(wrap), 32'(m_wrap));
      chk("tick", 32'(tick), 32'(m_tick));
      if (tick === 1'b1) cnt_tick++;
      if (wrap[2] === 1'b1) cnt_w2++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      // Count up through ten ticks.
      en = 1'b1; up = 1'b1; load = 1'b0;
      do_reset();
      chk("reset_hex", 32'(hex), 32'd0);
      chk("reset_wrap", 32'(wrap), 32'd0);
      chk("reset_tick", 32'(tick), 32'd0);
      cnt_tick = 0; cnt_w2 = 0;
      for (int i = 0; i < 40; i++) cyc();
      chk("up10_ticks", 32'(cnt_tick), 32'd10);
      chk("up10_hex", 32'(hex), 32'd10);
      chk("up10_bin", 32'(binary), 32'd0);
      chk("up10_dec", 32'(baseten), 32'd0);
      chk("up10_wrapdec_pulses", 32'(cnt_w2), 32'd1);

      // Count down from reset: all three wrap together.
      up = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) cyc();
      chk("down_hex", 32'(hex), 32'd15);
      chk("down_bin", 32'(binary), 32'd1);
      chk("down_dec", 32'(baseten), 32'd9);
      chk("down_wrap", 32'(wrap), 32'b111);
      cyc();
      chk("down_wrap_clear", 32'(wrap), 32'd0);

      // Load 12: decimal digit clamps to 9.
      load = 1'b1; load_val = 4'd12;
      cyc();
      load = 1'b0;
      chk("load_hex", 32'(hex), 32'd12);
      chk("load_bin", 32'(binary), 32'd0);
      chk("load_dec", 32'(baseten), 32'd9);
      chk("load_wrap", 32'(wrap), 32'd0);

      // Load on a tick cycle wins over stepping.
      for (int i = 0; i < P && m_tick == 0; i++) cyc();
      chk("tick_found", 32'(m_tick), 32'd1);
      load = 1'b1; load_val = 4'd5; en = 1'b1; up = 1'b1;
      cyc();
      load = 1'b0;
      chk("loadtick_hex", 32'(hex), 32'd5);
      chk("loadtick_dec", 32'(baseten), 32'd5);
      chk("loadtick_wrap", 32'(wrap), 32'd0);

      // Disabled: frozen digits, prescaler still running.
      en = 1'b0;
      cnt_tick = 0;
      for (int i = 0; i < 20; i++) cyc();
      chk("frozen_ticks", 32'(cnt_tick), 32'd5);
      chk("frozen_hex", 32'(hex), 32'd5);

      // Reset on a tick cycle with load asserted.
      en = 1'b1;
      for (int i = 0; i < P && m_tick == 0; i++) cyc();
      chk("tick_found2", 32'(tick), 32'd1);
      rst = 1'b1; load = 1'b1; load_val = 4'd7;
      cyc();
      rst = 1'b0; load = 1'b0;
      chk("rst_hex", 32'(hex), 32'd0);
      chk("rst_bin", 32'(binary), 32'd0);
      chk("rst_dec", 32'(baseten), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      cnt_tick = 0;
      for (int i = 0; i < P - 1; i++) cyc();
      chk("rst_first_tick", 32'(tick), 32'd1);
      chk("rst_tick_once", 32'(cnt_tick), 32'd1);

      // Randomised traffic.
      for (int i = 0; i < 10000; i++) begin
         rst      = ($urandom_range(0, 299) == 0);
         en       = ($urandom_range(0, 3) != 0);
         up       = $urandom_range(0, 1) == 1;
         load     = ($urandom_range(0, 15) == 0);
         load_val = 4'($urandom_range(0, 15));
         cyc();
         chk("inv_dec_range", 32'(baseten <= 4'd9), 32'd1);
         chk("inv_bin_upper", 32'(binary[3:1]), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
